// File: rtl/tribonacci_pkg.sv
// Shared state encoding and seed constants for the Tribonacci sequencer.
package tribonacci_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned SEED0 = 0;
    localparam int unsigned SEED1 = 1;
    localparam int unsigned SEED2 = 1;

endpackage

// File: rtl/trib_core.sv
// Three-register Tribonacci recurrence with per-register exact wrap tracking.
module trib_core
    import tribonacci_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] r0,
    output logic             w0
);

    logic [WIDTH-1:0] r0_q, r1_q, r2_q;
    logic             w0_q, w1_q, w2_q;
    logic [WIDTH+1:0] sum_d;
    logic             w2_d;

    // The sequence never decreases, so once any term has wrapped every later term has too.
    always_comb begin
        sum_d = {2'b00, r0_q} + {2'b00, r1_q} + {2'b00, r2_q};
        w2_d  = (|sum_d[WIDTH+1:WIDTH]) | w0_q | w1_q | w2_q;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || load) begin
            r0_q <= WIDTH'(SEED0);
            r1_q <= WIDTH'(SEED1);
            r2_q <= WIDTH'(SEED2);
            w0_q <= 1'b0;
            w1_q <= 1'b0;
            w2_q <= 1'b0;
        end else if (step) begin
            r0_q <= r1_q;
            r1_q <= r2_q;
            r2_q <= sum_d[WIDTH-1:0];
            w0_q <= w1_q;
            w1_q <= w2_q;
            w2_q <= w2_d;
        end
    end

    assign r0 = r0_q;
    assign w0 = w0_q;

endmodule

// File: rtl/tribonacci_seq.sv
// Request/response sequencer: seeds the recurrence core, steps it n times, returns T(n).
module tribonacci_seq
    import tribonacci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_value,
    output logic             rsp_ovf,
    output logic             busy
);

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             req_ready_q, rsp_valid_q, busy_q;
    logic             load, step;

    assign load = (state_q == IDLE) && req_valid;
    assign step = (state_q == RUN) && (cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= RUN;
                        cnt_q       <= req_n;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - IDX_W'(1);
                    end else begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here keeps req_ready low for the whole handshake cycle.
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    trib_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .r0   (rsp_value),
        .w0   (rsp_ovf)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tribonacci_seq.sv
// Bench: drives a 32-bit and an 8-bit sequencer in lockstep and checks both against a model.
module tb_tribonacci_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, rsp_ready;
    logic [7:0]  req_n;
    logic        rr32, rv32, ov32, bz32;
    logic [31:0] val32;
    logic        rr8, rv8, ov8, bz8;
    logic [7:0]  val8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tribonacci_seq #(.WIDTH(32), .IDX_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr32), .req_n(req_n),
        .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_value(val32), .rsp_ovf(ov32), .busy(bz32)
    );

    tribonacci_seq #(.WIDTH(8), .IDX_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr8), .req_n(req_n),
        .rsp_valid(rv8), .rsp_ready(rsp_ready), .rsp_value(val8), .rsp_ovf(ov8), .busy(bz8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: T(k) mod 2^w in one list, true T(k) saturated at 2^w in another.
    function automatic void model(input int n, input int w, output logic [63:0] val, output logic ovf);
        longint unsigned cap, s;
        longint unsigned m[$];
        longint unsigned t[$];
        cap = 64'd1 << w;
        m = '{0, 1, 1};
        t = '{0, 1, 1};
        for (int k = 3; k <= n; k++) begin
            m.push_back((m[k-1] + m[k-2] + m[k-3]) % cap);
            s = t[k-1] + t[k-2] + t[k-3];
            t.push_back((s >= cap) ? cap : s);
        end
        val = m[n];
        ovf = (t[n] >= cap);
    endfunction

    task automatic run_req(input int n, input int hold, input logic [7:0] chg_n,
                           output logic [31:0] v32, output logic o32,
                           output logic [7:0] v8, output logic o8);
        int k;
        @(negedge clk);
        check("accept_ready", {rr32, rr8}, 2'b11);
        req_valid = 1'b1;
        req_n     = n[7:0];
        @(negedge clk);
        req_valid = 1'b0;
        req_n     = chg_n;
        check("run_busy", {bz32, bz8, rr32, rr8}, 4'b1100);
        k = 0;
        while (!rv32 && k <= 300) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, n + 1);
        check("rsp_valid8", rv8, 1);
        v32 = val32;
        o32 = ov32;
        v8  = val8;
        o8  = ov8;
        for (int h = 0; h < hold; h++) begin
            check("hold_stable", {rv32, rr32, bz32, val32, ov32, val8, ov8},
                  {1'b1, 1'b0, 1'b1, v32, o32, v8, o8});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("hs_no_ready", {rr32, rr8}, 2'b00);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_hs", {rv32, rr32, bz32, rv8, rr8, bz8}, 6'b010010);
    endtask

    typedef struct {
        int          n;
        logic [31:0] v32;
        logic        o32;
        logic [7:0]  v8;
        logic        o8;
    } vec_t;

    initial begin
        vec_t        vt[8];
        logic [31:0] g32;
        logic [7:0]  g8;
        logic        go32, go8, e_o32, e_o8, ok;
        logic [63:0] e32, e8;
        int          last, acc, k, n;

        vt[0] = '{0,   0, 1'b0,   0, 1'b0};
        vt[1] = '{1,   1, 1'b0,   1, 1'b0};
        vt[2] = '{2,   1, 1'b0,   1, 1'b0};
        vt[3] = '{3,   2, 1'b0,   2, 1'b0};
        vt[4] = '{10, 149, 1'b0, 149, 1'b0};
        vt[5] = '{11, 274, 1'b0,  18, 1'b1};
        vt[6] = '{12, 504, 1'b0, 248, 1'b1};
        vt[7] = '{7,   24, 1'b0,  24, 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_n     = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {rr32, rv32, bz32, ov32, val32, rr8, rv8, bz8, ov8, val8},
              {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        rst = 1'b0;

        // Directed table; n=7 also exercises 5 cycles of backpressure.
        for (int i = 0; i < 8; i++) begin
            run_req(vt[i].n, (vt[i].n == 7) ? 5 : 0, 8'hFF, g32, go32, g8, go8);
            check($sformatf("vec32_n%0d", vt[i].n), {go32, g32}, {vt[i].o32, vt[i].v32});
            check($sformatf("vec8_n%0d", vt[i].n), {go8, g8}, {vt[i].o8, vt[i].v8});
        end

        run_req(6, 0, 8'd2, g32, go32, g8, go8);
        check("req_n_ignored", g32, 13);

        // Back-to-back requests with req_valid and rsp_ready held high.
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 8'd4;
        rsp_ready = 1'b1;
        last = -1;
        acc  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rr32) begin
                if (last >= 0) check("accept_spacing", cyc - last, 7);
                last = cyc;
                acc++;
            end
            if (rv32) begin
                check("stream_value", val32, 4);
                check("stream_hs_no_ready", rr32, 0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("stream_accepts", acc, 6);
        k = 0;
        while (!rr32 && k < 20) begin
            @(negedge clk);
            k++;
        end
        rsp_ready = 1'b0;
        check("stream_drain", rr32, 1);

        // Reset three cycles into an n=20 request.
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 8'd20;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("midrun_reset", {rr32, rv32, bz32, ov32, val32}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (rv32 || rv8 || !rr32) ok = 1'b0;
            @(negedge clk);
        end
        check("no_rsp_after_reset", ok, 1);
        run_req(5, 0, 8'h33, g32, go32, g8, go8);
        check("post_reset_n5", {go32, g32}, {1'b0, 32'd7});

        // Randomized requests against the reference model, plus the largest index.
        for (int r = 0; r < 26; r++) begin
            n = (r == 25) ? 255 : int'($urandom_range(0, 50));
            run_req(n, int'($urandom_range(0, 3)), 8'($urandom), g32, go32, g8, go8);
            model(n, 32, e32, e_o32);
            model(n, 8, e8, e_o8);
            check($sformatf("rand32_n%0d", n), {go32, g32}, {e_o32, e32[31:0]});
            check($sformatf("rand8_n%0d", n), {go8, g8}, {e_o8, e8[7:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tribonacci_seq.md
# tribonacci_seq

Request/response sequencer that owns a three-register Tribonacci recurrence datapath and drives it to compute T(n) on demand. A requester hands over an index n through a valid/ready handshake. The block seeds the datapath, steps it exactly n times, and returns T(n) modulo 2^WIDTH plus an exact overflow flag. It sits between a host-side command interface and the free-running-style recurrence registers, which it gates with load/step enables.

## Interface
- WIDTH, 32, value width of the recurrence registers and result
- IDX_W, 8, width of the requested index n (max n = 2^IDX_W − 1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_n  in  IDX_W  requested index n
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_value  out  WIDTH  T(n) mod 2^WIDTH
- rsp_ovf  out  1  true T(n) ≥ 2^WIDTH
- busy  out  1  high in RUN or DONE

## Operation
- Seeds: T(0)=0, T(1)=1, T(2)=1. The datapath registers r0/r1/r2 hold T(k), T(k+1), T(k+2).
- Each register also carries a wrap bit w0/w1/w2. Seed wrap bits are 0.
- Step: r0←r1, r1←r2, r2←(r0+r1+r2) mod 2^WIDTH.
  - w0←w1, w1←w2.
  - w2←(carry out of the WIDTH+2-bit sum) OR w0 OR w1 OR w2.
- rsp_value=r0 and rsp_ovf=w0, both driven directly from registers.
- Overflow computed on T(n+1) or T(n+2) must not affect rsp_ovf.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, load the seeds, set cnt←req_n, go to RUN.
  - RUN: if cnt≠0, step and set cnt←cnt−1. If cnt==0, go to DONE with no step.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- req_ready is 0 in DONE, including during the rsp handshake cycle. No request can be accepted in the same cycle a response completes.
- In DONE, rsp_value and rsp_ovf are held stable while rsp_ready is low.
- The registers retain their values in IDLE. rsp_value is don't-care when rsp_valid=0.
- Reset:
  - All outputs go low, except req_ready=1 and rsp_value=0.
  - state=IDLE, cnt=0, r0/r1/r2 and w bits at seed values.
  - Reset asserted mid-RUN or mid-DONE abandons the request, and no response is produced.

## Timing
- Request accepted on edge E.
- rsp_valid rises after edge E+n+1, so latency is n+1 cycles. For n=0 the latency is 1 cycle.
- In RUN there is exactly one step per cycle. There are no bubbles.
- The earliest next acceptance is the edge after the response handshake edge.
- Throughput is one request per n+3 cycles with rsp_ready held high.
- req_n is sampled only on the accept edge. Later changes to req_n are ignored.

## Structure
- Package tribonacci_pkg holds:
  - state encoding localparams IDLE/RUN/DONE
  - seed constants SEED0=0, SEED1=1, SEED2=1
- Sub-module trib_core is parameterised by WIDTH.
  - Inputs: clk, rst, load, step.
  - Outputs: r0, w0.
  - It contains the three value+wrap registers, which reset to the seeds, and the adder.
  - load has priority over step.
- tribonacci_seq contains the FSM, the IDX_W-bit down-counter and the handshake logic.

## Test plan
- WIDTH=32: request n=0, then 1, 2, 3, 10 → rsp_value 0, 1, 1, 2, 149 respectively. rsp_ovf=0 for all. Each response arrives n+1 cycles after accept.
- WIDTH=8: n=10 → 149, ovf=0. n=11 → 18, ovf=1. n=12 → ovf=1. This covers the wrap bit being exact at the boundary.
- Backpressure: n=7, hold rsp_ready low for 5 cycles → rsp_valid stays 1, rsp_value=24 stable, req_ready=0. On release → IDLE next cycle.
- req_valid held high continuously with n=4 → results 4, 4, … with accepts spaced exactly 7 cycles apart. No acceptance occurs in the handshake cycle.
- Assert rst 3 cycles into an n=20 request → state=IDLE, rsp_valid never rises. A following n=5 request → 7.
- req_n changed during RUN from 6 to 2 → result is still 13.
